// File: rtl/btn_gesture_decoder.sv
// Raw active-low button -> synchroniser -> counter debouncer -> gesture FSM (short/long/double pulses).
// Define GESTURE_REPEAT_EN to add the auto-repeat pulse while the button stays held past a long press.
module btn_gesture_decoder #(
    parameter int DEB_CYCLES    = 100_000,
    parameter int LONG_CYCLES   = 4_000_000,
    parameter int GAP_CYCLES    = 750_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_debounce,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_press
);

    localparam int LG_MAX = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int T_MAX  = (LG_MAX > REPEAT_CYCLES) ? LG_MAX : REPEAT_CYCLES;
    localparam int TW     = $clog2(T_MAX + 1);
    localparam int DW     = $clog2(DEB_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT = {TW{1'b1}};
`ifdef GESTURE_REPEAT_EN
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_t;

    logic          sync_meta;
    logic          sync_btn;
    logic [DW-1:0] deb_cnt;
    logic          deb_q;
    logic          dn;
    logic          up;
    state_t        state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;

    // Synchroniser and debouncer; reset values match a released button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta    <= 1'b1;
            sync_btn     <= 1'b1;
            btn_debounce <= 1'b1;
            deb_cnt      <= '0;
            deb_q        <= 1'b1;
        end else begin
            sync_meta <= btn;
            sync_btn  <= sync_meta;
            deb_q     <= btn_debounce;
            if (sync_btn != btn_debounce) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_debounce <= ~btn_debounce;
                    deb_cnt      <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Edge events come from the registered copy, one cycle behind btn_debounce.
    assign dn = deb_q & ~btn_debounce;
    assign up = ~deb_q & btn_debounce;
    assign timer_inc = (timer == TIMER_SAT) ? timer : timer + 1'b1;

`ifndef GESTURE_REPEAT_EN
    assign repeat_press = 1'b0;
`endif

    // Gesture FSM: edges are tested before timer expiry so an edge always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            pressed      <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
`ifdef GESTURE_REPEAT_EN
            repeat_press <= 1'b0;
`endif
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
`ifdef GESTURE_REPEAT_EN
            repeat_press <= 1'b0;
`endif
            timer <= timer_inc;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (dn) begin
                        state   <= PRESS1;
                        pressed <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (up) begin
                        state   <= WAIT2;
                        timer   <= '0;
                        pressed <= 1'b0;
                    end else if (timer == LONG_LAST) begin
                        state      <= HELD;
                        timer      <= '0;
                        long_press <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (dn) begin
                        state   <= PRESS2;
                        timer   <= '0;
                        pressed <= 1'b1;
                    end else if (timer == GAP_LAST) begin
                        state       <= IDLE;
                        timer       <= '0;
                        short_press <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (up) begin
                        state        <= IDLE;
                        timer        <= '0;
                        pressed      <= 1'b0;
                        double_press <= 1'b1;
                    end else if (timer == LONG_LAST) begin
                        state      <= HELD;
                        timer      <= '0;
                        long_press <= 1'b1;
                    end
                end
                HELD: begin
                    if (up) begin
                        state   <= IDLE;
                        timer   <= '0;
                        pressed <= 1'b0;
                    end else begin
`ifdef GESTURE_REPEAT_EN
                        if (timer == REP_LAST) begin
                            timer        <= '0;
                            repeat_press <= 1'b1;
                        end
`else
                        timer <= '0;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    timer   <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed bench for btn_gesture_decoder with shortened timing constants and a pulse-event scoreboard.
module tb_btn_gesture_decoder;

    localparam int DEB  = 20;
    localparam int LONG = 400;
    localparam int GAP  = 100;
    localparam int REP  = 50;

    localparam logic [7:0] EV_SHORT  = 8'd1;
    localparam logic [7:0] EV_LONG   = 8'd2;
    localparam logic [7:0] EV_DOUBLE = 8'd3;
    localparam logic [7:0] EV_REPEAT = 8'd4;

    logic clk;
    logic rst;
    logic btn;
    logic btn_debounce;
    logic pressed;
    logic short_press;
    logic long_press;
    logic double_press;
    logic repeat_press;

    btn_gesture_decoder #(
        .DEB_CYCLES   (DEB),
        .LONG_CYCLES  (LONG),
        .GAP_CYCLES   (GAP),
        .REPEAT_CYCLES(REP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .btn_debounce(btn_debounce),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .repeat_press(repeat_press)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_t[$];
    int         t_rise = 0;
    int         t_fall = 0;
    int         t_deb_fall = 0;
    int         n_deb_fall = 0;
    int         n_multi = 0;
    logic       pressed_d = 1'b0;
    logic       deb_d = 1'b1;
    int         n_checks = 0;
    int         n_pass = 0;

    // Monitor samples outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (short_press)  begin got_q.push_back(EV_SHORT);  got_t.push_back(cyc); end
        if (long_press)   begin got_q.push_back(EV_LONG);   got_t.push_back(cyc); end
        if (double_press) begin got_q.push_back(EV_DOUBLE); got_t.push_back(cyc); end
        if (repeat_press) begin got_q.push_back(EV_REPEAT); got_t.push_back(cyc); end
        if ((int'(short_press) + int'(long_press) + int'(double_press) + int'(repeat_press)) > 1)
            n_multi++;
        if (pressed && !pressed_d) t_rise = cyc;
        if (!pressed && pressed_d) t_fall = cyc;
        if (!btn_debounce && deb_d) begin
            t_deb_fall = cyc;
            n_deb_fall++;
        end
        pressed_d = pressed;
        deb_d     = btn_debounce;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Driver tasks: inputs change just after a falling edge.
    task automatic hold_low(input int n);
        btn = 1'b0;
        repeat (n) @(negedge clk);
        btn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic compare_sb(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_event"}, got_q[i], exp_q[i]);
    endtask

    int t0;
    int base;

    initial begin
        btn = 1'b1;
        rst = 1'b1;
        idle(3);
        check("rst_btn_debounce", btn_debounce, 1);
        check("rst_pressed", pressed, 0);
        check("rst_short", short_press, 0);
        check("rst_long", long_press, 0);
        check("rst_double", double_press, 0);
        check("rst_repeat", repeat_press, 0);
        rst = 1'b0;
        idle(5);

        // Glitch shorter than the debounce window
        clear_sb();
        base = n_deb_fall;
        hold_low(15);
        idle(100);
        check("glitch_deb_falls", n_deb_fall - base, 0);
        check("glitch_deb_level", btn_debounce, 1);
        compare_sb("glitch");

        // Single short press
        clear_sb();
        t0 = cyc;
        hold_low(60);
        check("short_deb_latency", t_deb_fall - t0, DEB + 2);
        check("short_pressed_rise", t_rise - t0, DEB + 3);
        idle(250);
        exp_q.push_back(EV_SHORT);
        compare_sb("short");
        if (got_t.size() > 0) check("short_delay", got_t[0] - t_fall, GAP);

        // Double press
        clear_sb();
        hold_low(60);
        idle(40);
        hold_low(60);
        idle(250);
        exp_q.push_back(EV_DOUBLE);
        compare_sb("double");
        if (got_t.size() > 0) check("double_at_up", got_t[0] - t_fall, 0);

        // Long press; with auto-repeat one repeat lands before release, the one at release is beaten by up
        clear_sb();
        hold_low(500);
        idle(200);
        exp_q.push_back(EV_LONG);
`ifdef GESTURE_REPEAT_EN
        exp_q.push_back(EV_REPEAT);
`endif
        compare_sb("long");
        if (got_t.size() > 0) check("long_delay", got_t[0] - t_rise, LONG);
        check("long_released", pressed, 0);

        // Long hold for auto-repeat
        clear_sb();
        hold_low(600);
        idle(200);
        exp_q.push_back(EV_LONG);
`ifdef GESTURE_REPEAT_EN
        exp_q.push_back(EV_REPEAT);
        exp_q.push_back(EV_REPEAT);
        exp_q.push_back(EV_REPEAT);
`endif
        compare_sb("repeat");
`ifdef GESTURE_REPEAT_EN
        if (got_t.size() > 2) begin
            check("repeat_first", got_t[1] - got_t[0], REP);
            check("repeat_second", got_t[2] - got_t[0], 2 * REP);
        end
`endif

        // Reset in the middle of PRESS1
        clear_sb();
        btn = 1'b0;
        idle(200);
        check("mid_pressed", pressed, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_pressed", pressed, 0);
        check("mid_rst_deb", btn_debounce, 1);
        check("mid_rst_pulses", {short_press, long_press, double_press, repeat_press}, 0);
        btn = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(300);
        compare_sb("reset_abort");
        check("reset_abort_pressed", pressed, 0);

        check("onehot_violations", n_multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
